// File: rtl/step_pulse_gen.sv
// Stepper pulse generator: pulls {dir, interval, count} moves from an upstream queue
// and emits step/dir pin activity with a running signed position count.
module step_pulse_gen #(
    parameter int unsigned PULSE_TICKS     = 2,
    parameter int unsigned DIR_SETUP_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [64:0] mq_data,
    input  logic        mq_avail,
    output logic        mq_pull,
    output logic        step_pin,
    output logic        dir_pin,
    output logic [31:0] position,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

    localparam logic [31:0] MIN_IVL = 32'(2 * PULSE_TICKS);
    localparam logic [31:0] MIN_REV = 32'(PULSE_TICKS + DIR_SETUP_TICKS);
    localparam logic [31:0] PW_LOAD = 32'(PULSE_TICKS - 1);
    localparam logic [31:0] DIR_LAG = (PULSE_TICKS > 1) ? 32'(PULSE_TICKS - 2) : '0;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] steps_q, steps_d;
    logic [31:0] ieff_q, ieff_d;
    logic [31:0] dly_q, dly_d;
    logic [31:0] nst_q, nst_d;
    logic        mv_dir_q, mv_dir_d;
    logic        dir_pend_q, dir_pend_d;
    logic        dir_new_q, dir_new_d;
    logic [31:0] dir_cnt_q, dir_cnt_d;
    logic [31:0] pw_q, pw_d;
    logic        step_q, step_d;
    logic        dir_q, dir_d;
    logic [31:0] pos_q, pos_d;
    logic        busy_q, busy_d;

    logic        eligible;
    logic        rise;
    logic [31:0] ivl_in;
    logic [31:0] ieff_in;
    logic [31:0] rev_in;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        steps_d    = steps_q;
        ieff_d     = ieff_q;
        dly_d      = dly_q;
        nst_d      = nst_q;
        mv_dir_d   = mv_dir_q;
        dir_pend_d = dir_pend_q;
        dir_new_d  = dir_new_q;
        dir_cnt_d  = dir_cnt_q;
        pw_d       = pw_q;
        step_d     = step_q;
        dir_d      = dir_q;
        pos_d      = pos_q;
        rise       = 1'b0;

        eligible = (state_q == IDLE) ||
                   ((state_q == WAIT) && (cnt_q == '0) && (steps_q <= 32'd1));
        mq_pull  = !rst && eligible && mq_avail;

        ivl_in  = mq_data[63:32];
        ieff_in = (ivl_in > MIN_IVL) ? ivl_in : MIN_IVL;
        rev_in  = (ieff_in > MIN_REV) ? ieff_in : MIN_REV;

        if (dir_pend_q) begin
            if (dir_cnt_q == '0) begin
                dir_d      = dir_new_q;
                dir_pend_d = 1'b0;
            end else begin
                dir_cnt_d = dir_cnt_q - 32'd1;
            end
        end

        if (mq_pull) begin
            mv_dir_d = mq_data[64];
            ieff_d   = ieff_in;
            dly_d    = (mq_data[64] == dir_q) ? ieff_in : rev_in;
            nst_d    = mq_data[31:0];
            if (PULSE_TICKS == 1) begin
                dir_d = mq_data[64];
            end else begin
                dir_pend_d = 1'b1;
                dir_new_d  = mq_data[64];
                dir_cnt_d  = DIR_LAG;
            end
        end

        // step_pin is registered, so the rise is decided one cycle early and the
        // countdown is loaded with D-2 so that it reaches zero in the rise cycle.
        case (state_q)
            IDLE: begin
                if (mq_pull) state_d = LOAD;
            end
            LOAD: begin
                cnt_d   = dly_q - 32'd2;
                steps_d = nst_q;
                state_d = WAIT;
                if ((dly_q == 32'd2) && (nst_q != '0)) rise = 1'b1;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (steps_q != '0) begin
                        pos_d   = mv_dir_q ? (pos_q + 32'd1) : (pos_q - 32'd1);
                        steps_d = steps_q - 32'd1;
                    end
                    if (steps_q > 32'd1) begin
                        cnt_d = ieff_q - 32'd1;
                    end else begin
                        state_d = mq_pull ? LOAD : IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                    if ((cnt_q == 32'd1) && (steps_q != '0)) rise = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rise) begin
            step_d = 1'b1;
            pw_d   = PW_LOAD;
        end else if (step_q) begin
            if (pw_q == '0) step_d = 1'b0;
            else            pw_d   = pw_q - 32'd1;
        end

        busy_d = (state_d != IDLE) || step_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            steps_q    <= '0;
            ieff_q     <= '0;
            dly_q      <= '0;
            nst_q      <= '0;
            mv_dir_q   <= 1'b0;
            dir_pend_q <= 1'b0;
            dir_new_q  <= 1'b0;
            dir_cnt_q  <= '0;
            pw_q       <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            pos_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            steps_q    <= steps_d;
            ieff_q     <= ieff_d;
            dly_q      <= dly_d;
            nst_q      <= nst_d;
            mv_dir_q   <= mv_dir_d;
            dir_pend_q <= dir_pend_d;
            dir_new_q  <= dir_new_d;
            dir_cnt_q  <= dir_cnt_d;
            pw_q       <= pw_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            pos_q      <= pos_d;
            busy_q     <= busy_d;
        end
    end

    assign step_pin = step_q;
    assign dir_pin  = dir_q;
    assign position = pos_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: single-move vector table, directed multi-move sequences,
// and random move streams checked cycle by cycle against a timeline model.
module tb_step_pulse_gen;

    localparam int PT   = 2;
    localparam int DST  = 4;
    localparam int MAXC = 2048;
    localparam int MAXM = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [64:0] mq_data;
    logic        mq_avail;
    logic        mq_pull;
    logic        step_pin;
    logic        dir_pin;
    logic [31:0] position;
    logic        busy;

    always #5 clk = ~clk;

    step_pulse_gen #(.PULSE_TICKS(PT), .DIR_SETUP_TICKS(DST)) dut (
        .clk      (clk),
        .rst      (rst),
        .mq_data  (mq_data),
        .mq_avail (mq_avail),
        .mq_pull  (mq_pull),
        .step_pin (step_pin),
        .dir_pin  (dir_pin),
        .position (position),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Move list shared by the directed and random runs.
    bit          mv_dir [MAXM];
    int          mv_ivl [MAXM];
    int          mv_cnt [MAXM];
    int          mv_gap [MAXM];
    int          pulled_at [MAXM];
    int          n_mv;

    // Expected per-cycle timeline.
    bit          e_step [MAXC];
    bit          e_dir  [MAXC];
    bit          e_pull [MAXC];
    bit          e_busy [MAXC];
    logic [31:0] e_pos  [MAXC];
    int          delta  [MAXC];
    int          last_c;

    task automatic build_model();
        int e, r, rp, avail, ieff, dly, t, acc;
        bit cur;
        for (int c = 0; c < MAXC; c++) begin
            e_step[c] = 0; e_dir[c] = 0; e_pull[c] = 0; e_busy[c] = 0; delta[c] = 0;
        end
        e = 0; rp = 0; cur = 0; r = 0;
        for (int i = 0; i < n_mv; i++) begin
            avail = (i == 0) ? mv_gap[0] : rp + 1 + mv_gap[i];
            r = (avail > e) ? avail : e;
            e_pull[r] = 1;
            ieff = (mv_ivl[i] > 2 * PT) ? mv_ivl[i] : 2 * PT;
            dly  = ieff;
            if (mv_dir[i] != cur && dly < PT + DST) dly = PT + DST;
            for (int c = r + PT; c < MAXC; c++) e_dir[c] = mv_dir[i];
            cur = mv_dir[i];
            for (int k = 0; k < mv_cnt[i]; k++) begin
                t = r + dly + k * ieff;
                for (int w = 0; w < PT; w++) e_step[t + w] = 1;
                delta[t + 1] += mv_dir[i] ? 1 : -1;
            end
            e = (mv_cnt[i] > 0) ? r + dly + (mv_cnt[i] - 1) * ieff : r + dly;
            for (int c = r + 1; c <= e; c++) e_busy[c] = 1;
            rp = r;
        end
        last_c = e + PT + 3;
        acc = 0;
        for (int c = 0; c < MAXC; c++) begin
            acc += delta[c];
            e_pos[c] = 32'(acc);
            if (e_step[c]) e_busy[c] = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        mq_avail = 1'b0;
        mq_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_moves(input string tag);
        int mi, prt, art;
        build_model();
        for (int i = 0; i < MAXM; i++) pulled_at[i] = -1;
        reset_dut();
        mi = 0; prt = 0;
        for (int c = 0; c <= last_c; c++) begin
            mq_avail = 1'b0;
            mq_data  = '0;
            if (mi < n_mv) begin
                art = (mi == 0) ? mv_gap[0] : prt + 1 + mv_gap[mi];
                if (c >= art) begin
                    mq_avail = 1'b1;
                    mq_data  = {mv_dir[mi], 32'(mv_ivl[mi]), 32'(mv_cnt[mi])};
                end
            end
            @(negedge clk);
            chk($sformatf("%s step@%0d", tag, c), 32'(step_pin), 32'(e_step[c]));
            chk($sformatf("%s dir@%0d",  tag, c), 32'(dir_pin),  32'(e_dir[c]));
            chk($sformatf("%s pos@%0d",  tag, c), position,      e_pos[c]);
            chk($sformatf("%s pull@%0d", tag, c), 32'(mq_pull),  32'(e_pull[c]));
            chk($sformatf("%s busy@%0d", tag, c), 32'(busy),     32'(e_busy[c]));
            if (mq_pull === 1'b1 && mi < n_mv) begin
                pulled_at[mi] = c;
                prt = c;
                mi++;
            end
            tick();
        end
        chk($sformatf("%s moves_pulled", tag), 32'(mi), 32'(n_mv));
    endtask

    task automatic set_mv(input int i, input bit d, input int ivl, input int cnt, input int gap);
        mv_dir[i] = d; mv_ivl[i] = ivl; mv_cnt[i] = cnt; mv_gap[i] = gap;
    endtask

    typedef struct {
        bit          dir;
        int          ivl;
        int          cnt;
        int          first_rise;
        int          last_rise;
        int          nrise;
        logic [31:0] pos;
        int          dir_at;
        int          idle_at;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input int idx, input vec_t v);
        int first_r, last_r, nr, dat, iat, npull;
        bit prev_step;
        reset_dut();
        first_r = -1; last_r = -1; nr = 0; dat = -1; iat = -1; npull = 0; prev_step = 0;
        for (int c = 0; c < 60; c++) begin
            mq_avail = (npull == 0);
            mq_data  = {v.dir, 32'(v.ivl), 32'(v.cnt)};
            @(negedge clk);
            if (c == 0) chk($sformatf("vec%0d first_pull", idx), 32'(mq_pull), 32'd1);
            if (step_pin === 1'b1 && !prev_step) begin
                if (first_r < 0) first_r = c;
                last_r = c;
                nr++;
            end
            prev_step = (step_pin === 1'b1);
            if (dat < 0 && dir_pin !== 1'b0) dat = c;
            if (iat < 0 && c >= 1 && busy === 1'b0) iat = c;
            if (mq_pull === 1'b1) npull++;
            tick();
        end
        chk($sformatf("vec%0d first_rise", idx), 32'(first_r), 32'(v.first_rise));
        chk($sformatf("vec%0d last_rise",  idx), 32'(last_r),  32'(v.last_rise));
        chk($sformatf("vec%0d nrise",      idx), 32'(nr),      32'(v.nrise));
        chk($sformatf("vec%0d position",   idx), position,     v.pos);
        chk($sformatf("vec%0d dir_at",     idx), 32'(dat),     32'(v.dir_at));
        chk($sformatf("vec%0d idle_at",    idx), 32'(iat),     32'(v.idle_at));
        chk($sformatf("vec%0d pulls",      idx), 32'(npull),   32'd1);
    endtask

    initial begin
        rst = 1'b1; mq_avail = 1'b0; mq_data = '0;

        //          dir ivl cnt first last n  pos           dir_at idle_at
        vecs[0] = '{1'b1, 10, 3, 10, 30, 3, 32'd3,          2, 32};
        vecs[1] = '{1'b0, 10, 2, 10, 20, 2, 32'hFFFF_FFFE, -1, 22};
        vecs[2] = '{1'b0,  1, 3,  4, 12, 3, 32'hFFFF_FFFD, -1, 14};
        vecs[3] = '{1'b1,  0, 2,  6, 10, 2, 32'd2,          2, 12};
        vecs[4] = '{1'b1,  5, 0, -1, -1, 0, 32'd0,          2,  7};
        vecs[5] = '{1'b0,  0, 1,  4,  4, 1, 32'hFFFF_FFFF, -1,  6};
        vecs[6] = '{1'b1,  7, 1,  7,  7, 1, 32'd1,          2,  9};
        vecs[7] = '{1'b1,  3, 2,  6, 10, 2, 32'd2,          2, 12};
        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Back-to-back: second move pulled in the cycle of the first move's last rise.
        n_mv = 2;
        set_mv(0, 1'b1, 10, 3, 0);
        set_mv(1, 1'b1,  5, 2, 0);
        run_moves("b2b");
        chk("b2b pull1", 32'(pulled_at[1]), 32'd30);
        chk("b2b final_pos", position, 32'd5);

        // Reversal pulled on the rise cycle T=6 of a dir=1 step.
        set_mv(0, 1'b1, 4, 1, 0);
        set_mv(1, 1'b0, 4, 1, 0);
        run_moves("rev");
        chk("rev pull1", 32'(pulled_at[1]), 32'd6);

        // Dwell with the follow-up move only offered at R+25.
        set_mv(0, 1'b0, 20, 0, 0);
        set_mv(1, 1'b0,  3, 1, 24);
        run_moves("dwell_late");
        chk("dwell_late pull1", 32'(pulled_at[1]), 32'd25);

        set_mv(1, 1'b0, 3, 1, 0);
        run_moves("dwell_now");
        chk("dwell_now pull1", 32'(pulled_at[1]), 32'd20);

        // Reset during the second cycle of a pulse.
        reset_dut();
        mq_avail = 1'b1;
        mq_data  = {1'b1, 32'd10, 32'd3};
        @(negedge clk);
        chk("rst first_pull", 32'(mq_pull), 32'd1);
        tick();
        mq_avail = 1'b0;
        repeat (9) tick();
        @(negedge clk);
        chk("rst rise10", 32'(step_pin), 32'd1);
        tick();
        rst      = 1'b1;
        mq_avail = 1'b1;
        mq_data  = {1'b1, 32'd4, 32'd1};
        @(negedge clk);
        chk("rst pull_in_rst", 32'(mq_pull), 32'd0);
        chk("rst pulse_2nd", 32'(step_pin), 32'd1);
        tick();
        @(negedge clk);
        chk("rst step", 32'(step_pin), 32'd0);
        chk("rst dir",  32'(dir_pin),  32'd0);
        chk("rst pos",  position,      32'd0);
        chk("rst busy", 32'(busy),     32'd0);
        chk("rst pull_held", 32'(mq_pull), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst release_pull", 32'(mq_pull), 32'd1);
        tick();
        mq_avail = 1'b0;
        @(negedge clk);
        chk("rst busy_after", 32'(busy), 32'd1);
        chk("rst dir_pre",    32'(dir_pin), 32'd0);
        tick();
        @(negedge clk);
        chk("rst dir_post",   32'(dir_pin), 32'd1);
        tick();

        // Random move streams.
        for (int round = 0; round < 4; round++) begin
            n_mv = 10;
            for (int i = 0; i < n_mv; i++) begin
                set_mv(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)),
                       int'($urandom_range(0, 4)),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : 0);
            end
            run_moves($sformatf("rnd%0d", round));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
